hiscore_ram_port: RTL and testbench

Game-core-side responder for the high-score save/restore bus. When the high-score engine raises `hs_access`, this block halts the CPU and waits for its bus to go quiet. It then takes over the second port of the work RAM and serves byte reads and writes at a fixed latency. When the engine lets go, it returns the RAM to the game. It sits inside the game core between the high-score bus and the work RAM, and drives the core's pause/halt input.

---
 rtl/hiscore_ram_port.sv | 135 +++++++++++++
 tb/tb_hiscore_ram_port.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_port.sv
`default_nettype none
// ============================================================================
// hiscore_ram_port : halts the CPU, takes over work-RAM port 2 for the
// high-score engine and serves pipelined byte reads/writes.
// Revision: 1.0
// ============================================================================
module hiscore_ram_port #(
    parameter logic [15:0] RAM_BASE = 16'hC000,
    parameter int          RAM_AW   = 12,
    parameter int          SETTLE   = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              hs_access,
    input  logic [15:0]       hs_address,
    input  logic [7:0]        hs_data_in,
    input  logic              hs_write,
    output logic [7:0]        hs_data_out,
    output logic              hs_ready,
    output logic              hs_oor,
    output logic              cpu_halt,
    input  logic              cpu_busy,
    output logic              ram_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HALT    = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  settle_cnt;
    logic [15:0] offset;
    logic        in_range;
    logic        honour;
    logic        halt_entry;
    logic        rd_v1;
    logic        rd_v2;
    logic        rd_oor1;
    logic        rd_oor2;

    // Subtraction wraps, so addresses below RAM_BASE land far out of range.
    assign offset     = hs_address - RAM_BASE;
    assign in_range   = ((offset >> RAM_AW) == 16'd0);
    assign honour     = (state == ST_OWN) && hs_access;
    assign halt_entry = (state == ST_IDLE) && (state_next == ST_HALT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (hs_access) state_next = ST_HALT;
            end
            ST_HALT: begin
                if (!hs_access)
                    state_next = ST_RELEASE;
                else if ((settle_cnt == 8'd0) && !cpu_busy)
                    state_next = ST_OWN;
            end
            ST_OWN: begin
                if (!hs_access) state_next = ST_RELEASE;
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they change on entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cpu_halt   <= 1'b0;
            ram_sel    <= 1'b0;
            hs_ready   <= 1'b0;
            settle_cnt <= 8'd0;
            hs_oor     <= 1'b0;
        end else begin
            state    <= state_next;
            cpu_halt <= (state_next != ST_IDLE);
            ram_sel  <= (state_next == ST_OWN);
            hs_ready <= (state_next == ST_OWN);

            if (halt_entry)
                settle_cnt <= SETTLE_C;
            else if (state == ST_HALT) begin
                if (cpu_busy)
                    settle_cnt <= SETTLE_C;
                else if (settle_cnt != 8'd0)
                    settle_cnt <= settle_cnt - 8'd1;
            end

            if (halt_entry)
                hs_oor <= 1'b0;
            else if (honour && !in_range)
                hs_oor <= 1'b1;
        end
    end

    // Read pipeline: address register, RAM register, then output register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr    <= '0;
            ram_din     <= 8'h00;
            ram_we      <= 1'b0;
            rd_v1       <= 1'b0;
            rd_v2       <= 1'b0;
            rd_oor1     <= 1'b0;
            rd_oor2     <= 1'b0;
            hs_data_out <= 8'h00;
        end else begin
            ram_we <= honour && in_range && hs_write;
            if (honour && in_range) begin
                ram_addr <= offset[RAM_AW-1:0];
                ram_din  <= hs_data_in;
            end
            rd_v1   <= honour && !hs_write;
            rd_oor1 <= !in_range;
            rd_v2   <= rd_v1;
            rd_oor2 <= rd_oor1;
            if (rd_v2)
                hs_data_out <= rd_oor2 ? 8'h00 : ram_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hiscore_ram_port.sv
`default_nettype none
// ============================================================================
// tb_hiscore_ram_port : scoreboard bench for hiscore_ram_port with a
// synchronous work-RAM model on port 2.
// Revision: 1.0
// ============================================================================
module tb_hiscore_ram_port;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs_access = 1'b0;
    logic [15:0] hs_address = 16'h0000;
    logic [7:0]  hs_data_in = 8'h00;
    logic        hs_write = 1'b0;
    logic [7:0]  hs_data_out;
    logic        hs_ready;
    logic        hs_oor;
    logic        cpu_halt;
    logic        cpu_busy = 1'b0;
    logic        ram_sel;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;

    logic [7:0]  mem    [0:4095];
    logic [7:0]  shadow [0:4095];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  val;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    hiscore_ram_port #(
        .RAM_BASE (16'hC000),
        .RAM_AW   (12),
        .SETTLE   (8)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .hs_access   (hs_access),
        .hs_address  (hs_address),
        .hs_data_in  (hs_data_in),
        .hs_write    (hs_write),
        .hs_data_out (hs_data_out),
        .hs_ready    (hs_ready),
        .hs_oor      (hs_oor),
        .cpu_halt    (cpu_halt),
        .cpu_busy    (cpu_busy),
        .ram_sel     (ram_sel),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Each expected read is due a fixed number of cycles after it was driven.
    always @(negedge clk_sys) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            checks++;
            if (hs_data_out !== e.val) begin
                failures++;
                $display("FAIL read_%h hs_data_out=%h expected=%h", e.addr, hs_data_out, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        hs_address = a;
        hs_data_in = d;
        hs_write   = w;
    endtask

    task automatic expect_read(input logic [15:0] a, input logic [7:0] v);
        exp_t e;
        drive(a, 8'h00, 1'b0);
        e.addr = a;
        e.val  = v;
        e.due  = cyc + 3;
        sbq.push_back(e);
    endtask

    task automatic request_and_wait();
        hs_access = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hs_ready) break;
        end
        checks++;
        if (hs_ready !== 1'b1) begin
            failures++;
            $display("FAIL grant_wait hs_ready=%b expected=1", hs_ready);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sbq.size() > 0; i++) tick();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic release_bus();
        hs_write  = 1'b0;
        hs_access = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({cpu_halt, ram_sel, hs_ready, ram_we, hs_oor, hs_data_out, ram_addr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%b_%b_%b_%b_%h_%h expected=all zero",
                     cpu_halt, ram_sel, hs_ready, ram_we, hs_oor, hs_data_out, ram_addr);
        end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_grant();
        drive(16'hC020, 8'hEE, 1'b1);
        hs_access = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (cpu_halt !== 1'b1) begin
                failures++;
                $display("FAIL grant_halt e=%0d cpu_halt=%b expected=1", e, cpu_halt);
            end
            checks++;
            if (hs_ready !== (e >= 10) || ram_sel !== (e >= 10)) begin
                failures++;
                $display("FAIL grant_ready e=%0d hs_ready=%b ram_sel=%b expected=%b",
                         e, hs_ready, ram_sel, (e >= 10));
            end
            checks++;
            if (ram_we !== 1'b0) begin
                failures++;
                $display("FAIL grant_no_we e=%0d ram_we=%b expected=0", e, ram_we);
            end
            if (e == 10) hs_write = 1'b0;
        end
        checks++;
        if (mem[12'h020] !== shadow[12'h020]) begin
            failures++;
            $display("FAIL halt_write_ignored mem=%h expected=%h", mem[12'h020], shadow[12'h020]);
        end
        hs_access = 1'b0;
        tick();
        checks++;
        if ({hs_ready, ram_sel, cpu_halt} !== 3'b001) begin
            failures++;
            $display("FAIL release_n1 rdy_sel_halt=%b expected=001", {hs_ready, ram_sel, cpu_halt});
        end
        tick();
        checks++;
        if (cpu_halt !== 1'b0) begin
            failures++;
            $display("FAIL release_n2 cpu_halt=%b expected=0", cpu_halt);
        end
        tick();
    endtask

    task automatic test_busy_stall();
        hs_access = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            checks++;
            if (hs_ready !== (e >= 15) || cpu_halt !== 1'b1) begin
                failures++;
                $display("FAIL stall e=%0d hs_ready=%b cpu_halt=%b expected=%b/1",
                         e, hs_ready, cpu_halt, (e >= 15));
            end
            cpu_busy = (e >= 3 && e <= 5);
        end
        release_bus();
        hs_access = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (cpu_halt !== (e <= 5) || ram_sel !== 1'b0) begin
                failures++;
                $display("FAIL abort e=%0d cpu_halt=%b ram_sel=%b expected=%b/0",
                         e, cpu_halt, ram_sel, (e <= 5));
            end
            cpu_busy = (e >= 3 && e <= 5);
            if (e == 4) hs_access = 1'b0;
        end
        cpu_busy = 1'b0;
    endtask

    task automatic test_write_read();
        request_and_wait();
        drive(16'hC010, 8'hA5, 1'b1);
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'h010 || ram_din !== 8'hA5) begin
            failures++;
            $display("FAIL wr_issue we=%b addr=%h din=%h expected=1/010/a5", ram_we, ram_addr, ram_din);
        end
        shadow[12'h010] = 8'hA5;
        expect_read(16'hC010, shadow[12'h010]);
        tick();
        checks++;
        if (mem[12'h010] !== 8'hA5) begin
            failures++;
            $display("FAIL wr_ram mem=%h expected=a5", mem[12'h010]);
        end
        for (int i = 0; i < 4; i++) begin
            expect_read(16'hC000 + 16'(i), shadow[i]);
            tick();
        end
        drain();
        release_bus();
    endtask

    task automatic test_range_edges();
        request_and_wait();
        checks++;
        if (hs_oor !== 1'b0) begin
            failures++;
            $display("FAIL oor_initial hs_oor=%b expected=0", hs_oor);
        end
        drive(16'hCFFF, 8'h3C, 1'b1);
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'hFFF) begin
            failures++;
            $display("FAIL top_issue we=%b addr=%h expected=1/fff", ram_we, ram_addr);
        end
        shadow[12'hFFF] = 8'h3C;
        drive(16'hBFFF, 8'h11, 1'b1);
        tick();
        checks++;
        if (mem[12'hFFF] !== 8'h3C) begin
            failures++;
            $display("FAIL top_ram mem=%h expected=3c", mem[12'hFFF]);
        end
        checks++;
        if (ram_we !== 1'b0 || hs_oor !== 1'b1) begin
            failures++;
            $display("FAIL below_base we=%b oor=%b expected=0/1", ram_we, hs_oor);
        end
        drive(16'hD000, 8'h22, 1'b1);
        tick();
        checks++;
        if (ram_we !== 1'b0) begin
            failures++;
            $display("FAIL above_top we=%b expected=0", ram_we);
        end
        expect_read(16'hBFFF, 8'h00);
        tick();
        expect_read(16'hD000, 8'h00);
        tick();
        expect_read(16'hCFFF, 8'h3C);
        tick();
        expect_read(16'hC000, shadow[0]);
        tick();
        drain();
        release_bus();
        checks++;
        if (hs_oor !== 1'b1 || cpu_halt !== 1'b0) begin
            failures++;
            $display("FAIL oor_sticky oor=%b halt=%b expected=1/0", hs_oor, cpu_halt);
        end
        hs_access = 1'b1;
        tick();
        checks++;
        if (hs_oor !== 1'b0) begin
            failures++;
            $display("FAIL oor_clear hs_oor=%b expected=0", hs_oor);
        end
        request_and_wait();
        release_bus();
    endtask

    task automatic test_reset_mid_own();
        request_and_wait();
        for (int i = 0; i < 4; i++) begin
            drive(16'hC100 + 16'(i), 8'h80 + 8'(i), 1'b1);
            tick();
        end
        checks++;
        if (ram_we !== 1'b1 || ram_sel !== 1'b1) begin
            failures++;
            $display("FAIL burst_active we=%b sel=%b expected=1/1", ram_we, ram_sel);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({ram_sel, ram_we, cpu_halt, hs_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset sel_we_halt_rdy=%b expected=0000",
                     {ram_sel, ram_we, cpu_halt, hs_ready});
        end
        hs_access = 1'b0;
        hs_write  = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (cpu_halt !== 1'b0 || ram_sel !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle halt=%b sel=%b expected=0/0", cpu_halt, ram_sel);
        end
        hs_access = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (hs_ready !== (e >= 10)) begin
                failures++;
                $display("FAIL post_reset_grant e=%0d hs_ready=%b expected=%b", e, hs_ready, (e >= 10));
            end
        end
        release_bus();
    endtask

    task automatic test_rerequest();
        request_and_wait();
        hs_access = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            checks++;
            if (cpu_halt !== (e != 2) || hs_ready !== (e >= 12) || ram_sel !== (e >= 12)) begin
                failures++;
                $display("FAIL rereq e=%0d halt=%b rdy=%b sel=%b expected=%b/%b/%b",
                         e, cpu_halt, hs_ready, ram_sel, (e != 2), (e >= 12), (e >= 12));
            end
            if (e == 1) hs_access = 1'b1;
        end
        release_bus();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = i[7:0] ^ 8'h5A;
            shadow[i] = i[7:0] ^ 8'h5A;
        end
        test_reset();
        test_grant();
        test_busy_stall();
        test_write_read();
        test_range_edges();
        test_reset_mid_own();
        test_rerequest();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
